// File: rtl/gate_sweep_pkg.sv
// Shared types and truth-table constants for the gate sweep checker.
package gate_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Bit i is the gate output for input vector {a,b} = i.
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;

endpackage

// File: rtl/gate_sweep_if.sv
// Bundle between the sweep engine and its environment (control, gate pins, results).
interface gate_sweep_if;

  logic       start;
  logic       dut_out;
  logic       a;
  logic       b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] table_obs;
  logic [3:0] mismatch;

  // master: the sweep engine, which drives the gate inputs and reports results
  modport master (
    input  start, dut_out,
    output a, b, busy, done, pass, table_obs, mismatch
  );

  modport slave (
    output start, dut_out,
    input  a, b, busy, done, pass, table_obs, mismatch
  );

endinterface

// File: rtl/gate_sweep_timer.sv
// Settle counter: counts enabled cycles since the last clear; expired_o flags the last settle cycle.
module gate_sweep_timer #(
  parameter int unsigned SETTLE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(SETTLE + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == CW'(SETTLE - 1));

endmodule

// File: rtl/gate_sweep.sv
// Clocked sweep of a 2-input gate through all four input vectors, capturing and
// checking its truth table against EXPECTED.
module gate_sweep
  import gate_sweep_pkg::*;
#(
  parameter logic [3:0]  EXPECTED = TT_NAND,
  parameter int unsigned SETTLE   = 1
) (
  input logic          clk,
  input logic          rst,
  gate_sweep_if.master bus
);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic       a_q, a_d;
  logic       b_q, b_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [3:0] tbl_q, tbl_d;
  logic [3:0] mism_q, mism_d;

  logic tmr_clr, tmr_en, tmr_expired;

  gate_sweep_timer #(.SETTLE(SETTLE)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (tmr_clr),
    .en_i      (tmr_en),
    .expired_o (tmr_expired)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    tbl_d   = tbl_q;
    mism_d  = mism_q;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = WAIT;
          idx_d   = 2'd0;
          a_d     = 1'b0;
          b_d     = 1'b0;
          busy_d  = 1'b1;
          tbl_d   = 4'b0000;
          mism_d  = 4'b0000;
          pass_d  = 1'b0;
          tmr_clr = 1'b1;
        end
      end
      WAIT: begin
        tmr_en = 1'b1;
        if (tmr_expired) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        tbl_d[idx_q] = bus.dut_out;
        tmr_clr      = 1'b1;
        if (idx_q != 2'd3) begin
          idx_d   = idx_q + 2'd1;
          a_d     = idx_d[1];
          b_d     = idx_d[0];
          state_d = WAIT;
        end else begin
          // Verdict must include the bit captured on this very edge.
          state_d = DONE;
          a_d     = 1'b0;
          b_d     = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          mism_d  = tbl_d ^ EXPECTED;
          pass_d  = (tbl_d == EXPECTED);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      tbl_q   <= 4'b0000;
      mism_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      tbl_q   <= tbl_d;
      mism_q  <= mism_d;
    end
  end

  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.table_obs = tbl_q;
  assign bus.mismatch  = mism_q;

endmodule

// File: tb/tb_gate_sweep.sv
// Directed bench: two sweep engines (SETTLE=1 on a configurable gate, SETTLE=3 on an AND gate).
module tb_gate_sweep;
  import gate_sweep_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic start1, start3;
  int   mode1;  // 0 NAND, 1 AND, 2 stuck-at-1
  int   sel;
  int   n_chk  = 0;
  int   n_pass = 0;

  logic       o_a, o_b, o_busy, o_done, o_pass;
  logic [3:0] o_tbl, o_mis;

  always #5 clk = ~clk;

  gate_sweep_if if1 ();
  gate_sweep_if if3 ();

  assign if1.start = start1;
  assign if3.start = start3;

  always_comb begin
    case (mode1)
      0:       if1.dut_out = ~(if1.a & if1.b);
      1:       if1.dut_out = if1.a & if1.b;
      default: if1.dut_out = 1'b1;
    endcase
  end
  assign if3.dut_out = if3.a & if3.b;

  gate_sweep #(.EXPECTED(TT_NAND), .SETTLE(1)) u1 (.clk(clk), .rst(rst), .bus(if1.master));
  gate_sweep #(.EXPECTED(TT_AND),  .SETTLE(3)) u3 (.clk(clk), .rst(rst), .bus(if3.master));

  always_comb begin
    if (sel == 3) begin
      o_a = if3.a; o_b = if3.b; o_busy = if3.busy; o_done = if3.done;
      o_pass = if3.pass; o_tbl = if3.table_obs; o_mis = if3.mismatch;
    end else begin
      o_a = if1.a; o_b = if1.b; o_busy = if1.busy; o_done = if1.done;
      o_pass = if1.pass; o_tbl = if1.table_obs; o_mis = if1.mismatch;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic set_start(input int inst, input logic v);
    if (inst == 3) start3 = v;
    else start1 = v;
  endtask

  // One full sweep; k is the index of the posedge just before each negedge sample.
  task automatic sweep(input int inst, input int p, input logic [3:0] e_tbl,
                       input logic e_pass, input logic [3:0] e_mis, input bit poke);
    int dones;
    int v;
    dones = 0;
    sel = inst;
    @(negedge clk);
    set_start(inst, 1'b1);
    for (int k = 0; k <= 4*p + 1; k++) begin
      @(negedge clk);
      if (k == 0) set_start(inst, 1'b0);
      if (poke && (k == 2 || k == 4)) set_start(inst, 1'b1);
      if (poke && (k == 3 || k == 5)) set_start(inst, 1'b0);
      if (o_done) dones++;
      v = (k < 4*p) ? k / p : 0;
      check("ab",   32'({o_a, o_b}), 32'(v));
      check("busy", 32'(o_busy), 32'(k < 4*p));
      check("done", 32'(o_done), 32'(k == 4*p));
      if (k == 0) begin
        check("tbl_clr",  32'(o_tbl),  32'h0);
        check("pass_clr", 32'(o_pass), 32'h0);
        check("mis_clr",  32'(o_mis),  32'h0);
      end
      if (k == 4*p) begin
        check("table_obs", 32'(o_tbl),  32'(e_tbl));
        check("pass",      32'(o_pass), 32'(e_pass));
        check("mismatch",  32'(o_mis),  32'(e_mis));
      end
    end
    check("done_count", 32'(dones), 32'd1);
    if (poke) begin
      repeat (3) @(negedge clk);
      check("no_relaunch", 32'(o_busy), 32'h0);
    end
  endtask

  initial begin
    int dk [3];
    int nd;

    rst = 1'b1; start1 = 1'b0; start3 = 1'b0; mode1 = 0; sel = 1;
    repeat (2) @(negedge clk);
    check("rst_ab",    32'({if1.a, if1.b}), 32'h0);
    check("rst_busy",  32'(if1.busy), 32'h0);
    check("rst_done",  32'(if1.done), 32'h0);
    check("rst_pass",  32'(if1.pass), 32'h0);
    check("rst_tbl",   32'(if1.table_obs), 32'h0);
    check("rst_mis",   32'(if1.mismatch), 32'h0);
    check("rst_state", 32'(u1.state_q), 32'(IDLE));
    check("rst_busy3", 32'(if3.busy), 32'h0);
    rst = 1'b0;

    sweep(1, 2, 4'b0111, 1'b1, 4'b0000, 1'b0);   // NAND, expect NAND
    mode1 = 1;
    sweep(1, 2, 4'b1000, 1'b0, 4'b1111, 1'b0);   // AND, expect NAND
    mode1 = 2;
    sweep(1, 2, 4'b1111, 1'b0, 4'b1000, 1'b0);   // stuck-at-1
    sweep(3, 4, 4'b1000, 1'b1, 4'b0000, 1'b0);   // SETTLE=3 AND
    mode1 = 0;
    sweep(1, 2, 4'b0111, 1'b1, 4'b0000, 1'b1);   // stray start pulses ignored

    // start held high: done every 10 cycles
    sel = 1; nd = 0;
    for (int i = 0; i < 3; i++) dk[i] = -1;
    @(negedge clk);
    start1 = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (o_done) begin
        if (nd < 3) dk[nd] = k;
        nd++;
      end
    end
    start1 = 1'b0;
    check("held_ndone", 32'(nd), 32'd3);
    check("held_d0", 32'(dk[0]), 32'd8);
    check("held_d1", 32'(dk[1]), 32'd18);
    check("held_d2", 32'(dk[2]), 32'd28);
    repeat (12) @(negedge clk);
    check("held_idle", 32'(o_busy), 32'h0);

    // reset at edge 5 of a sweep
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_tbl",  32'(if1.table_obs), 32'h3);
    check("pre_rst_busy", 32'(if1.busy), 32'h1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_ab",    32'({if1.a, if1.b}), 32'h0);
    check("mid_rst_busy",  32'(if1.busy), 32'h0);
    check("mid_rst_tbl",   32'(if1.table_obs), 32'h0);
    check("mid_rst_state", 32'(u1.state_q), 32'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    sweep(1, 2, 4'b0111, 1'b1, 4'b0000, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/gate_sweep.md
# gate_sweep

Sequential stimulus-and-check stage for a 2-input combinational gate.
- On a start pulse it drives the gate's two inputs through all four combinations (00, 01, 10, 11) and waits a programmable settle time at each vector.
- It samples the gate's output, assembles the observed 4-entry truth table and compares it against an expected table.
- It sits directly upstream (drives `a`/`b`) and downstream (consumes `out`) of the NAND/AND gate cells, replacing hand-written `#delay` stimulus with a clocked, self-checking sweep.

## Interface
Parameters:
- `EXPECTED`, default 4'b0111 (NAND): expected truth table; bit i is the required gate output for input vector {a,b} = i.
- `SETTLE`, default 1: cycles each vector is held before sampling; legal range 1..255.

Ports:
- `clk`  in  1  single clock, rising-edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  begin a sweep; honoured only in IDLE.
- `dut_out`  in  1  output of the gate under test.
- `a`  out  1  gate input A (registered); equals idx[1].
- `b`  out  1  gate input B (registered); equals idx[0].
- `busy`  out  1  sweep in progress.
- `done`  out  1  one-cycle pulse when results are valid.
- `pass`  out  1  observed table == `EXPECTED`; held until next start.
- `table_obs`  out  4  observed truth table; bit i holds the sample for vector i.
- `mismatch`  out  4  `table_obs ^ EXPECTED`; held until next start.

## Operation
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: state IDLE, idx=0, cnt=0; `a`=`b`=0; `busy`=`done`=`pass`=0; `table_obs`=`mismatch`=4'b0000.
- Reset asserted mid-sweep aborts the sweep immediately. No partial results are retained.
- States: IDLE, WAIT, SAMPLE, DONE.
- IDLE: `start`=1 -> WAIT.
  - Sets idx=0 and cnt=0.
  - Drives `a`=`b`=0 and sets `busy`=1.
  - Clears `table_obs`, `mismatch` and `pass`.
- WAIT: cnt increments each cycle; at cnt==SETTLE-1 -> SAMPLE. WAIT therefore lasts exactly SETTLE cycles.
- SAMPLE: lasts one cycle. On its closing edge, `table_obs[idx]` <= `dut_out`.
  - If idx<3: idx++, `a`/`b` update to the new idx, cnt=0, -> WAIT.
  - If idx==3: -> DONE, with the following outputs:
    - `a`=`b`=0 and `busy`=0.
    - `pass` and `mismatch` are computed from the final table, including the bit just captured.
- DONE: `done`=1 for exactly one cycle, then -> IDLE.
- `start` is ignored in WAIT, SAMPLE and DONE (no queuing). `start` held high in IDLE re-launches a sweep on the cycle after DONE.
- `dut_out` is treated as combinational from `a`/`b`; the block adds no synchroniser.

## Timing
- Let edge 0 be the edge that samples `start`=1 in IDLE.
- Per-vector period is SETTLE+1 cycles. Vector i is captured at edge (i+1)·(SETTLE+1).
- `a`/`b` for vector i are valid from edge i·(SETTLE+1) until edge (i+1)·(SETTLE+1).
- `done` is high between edges 4·(SETTLE+1) and 4·(SETTLE+1)+1. `pass`, `table_obs` and `mismatch` are valid from edge 4·(SETTLE+1).
- `busy` is high from edge 0 to edge 4·(SETTLE+1).
- Worked example, SETTLE=1: captures at edges 2, 4, 6, 8; `done` high after edge 8. Total latency from start to done is 8 cycles.
- cnt width is $clog2(SETTLE+1); it never wraps, because it is reset on every vector.

## Structure
- Shared package `gate_sweep_pkg` holds:
  - State enum: IDLE, WAIT, SAMPLE, DONE.
  - Truth-table constants: TT_NAND=4'b0111, TT_AND=4'b1000, TT_OR=4'b1110, TT_XOR=4'b0110.
- One natural sub-module, `gate_sweep_timer`: the settle counter. Inputs are clear/enable; output is `expired` at cnt==SETTLE-1.
- FSM, idx, table and compare logic stay in the top module.

## Test plan
- NAND gate DUT, EXPECTED=TT_NAND, SETTLE=1, pulse start -> `a`/`b` sequence 00, 01, 10, 11 at 2-cycle spacing; `done` after edge 8; `table_obs`=4'b0111, `pass`=1, `mismatch`=0.
- AND gate DUT (NAND+NAND) with EXPECTED=TT_NAND -> `table_obs`=4'b1000, `mismatch`=4'b1111, `pass`=0.
- NAND DUT with `dut_out` forced stuck-at-1 -> `table_obs`=4'b1111, `mismatch`=4'b1000, `pass`=0.
- SETTLE=3, AND DUT, EXPECTED=TT_AND -> captures at edges 4, 8, 12, 16; `done` after edge 16; `pass`=1.
- `start` pulsed at edges 3 and 5 during a sweep -> ignored; exactly one `done`. `start` held high continuously -> back-to-back sweeps, with `done` every 4·(SETTLE+1)+2 cycles.
- Assert `rst` at edge 5 of a sweep -> within the same cycle: `a`=`b`=0, `busy`=0, `table_obs`=0, state IDLE. A new start then produces a correct full sweep.
